// File: rtl/core_pkg.sv
// Shared core definitions: instruction constants, 2-bit branch counter
// encodings and small decode/update helpers used by the fetch stage.
// Latency: n/a (package). Backpressure: n/a (package).
package core_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;

  // 2-bit saturating branch history counter; MSB is the taken prediction.
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strongly not-taken
    CNT_WNT = 2'b01,  // weakly not-taken (reset value)
    CNT_WT  = 2'b10,  // weakly taken
    CNT_ST  = 2'b11   // strongly taken
  } bht_cnt_e;

  // Sign-extended B-type immediate (13-bit byte offset, bit 0 always zero).
  function automatic logic [31:0] bimm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Saturating counter update toward the resolved outcome.
  function automatic bht_cnt_e cnt_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = bht_cnt_e'(cur + 2'd1);
    end else begin
      if (cur != CNT_SNT) nxt = bht_cnt_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/inst_fetch_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters.
// Latency: read is combinational from the counter flops; write lands on the next edge.
// Backpressure: none; the caller gates wr_en (e.g. with its stall).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (all counters -> weakly not-taken)
//   rd_idx / rd_cnt   read index and counter value (pre-update value on a same-index write)
//   wr_en / wr_idx    update strobe and index
//   wr_taken          resolved outcome: 1 increments, 0 decrements, both saturating
module bht
  import core_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  bht_cnt_e cnt_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_next(cnt_q[wr_idx], wr_taken);
    end
  end

  // Reading the flops directly means a same-cycle write is not bypassed:
  // the fetch predicts with the value that existed before the update.
  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, next-PC select, IF/ID register, optional bimodal predictor.
// Latency: 1 cycle fetch-to-ID (imem_data_i is combinational on imem_addr_o, captured into IF/ID).
// Backpressure: stall_i holds PC and IF/ID; jmp_i/branch_i redirect and flush IF/ID even while stalled.
//
// Configuration: define BRANCH_PRED_EN to build the BHT and the predicted-taken path;
// without it branch_pred_o is tied low and branch_resolve_i/branch_taken_i are ignored.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_i                   hazard stall from ID
//   jmp_i, pc_jmp_i           JAL redirect and target (highest priority)
//   branch_i, pc_branch_i     branch mispredict redirect and corrected PC
//   branch_resolve_i          ID holds a conditional branch this cycle
//   branch_taken_i            its actual outcome
//   imem_addr_o, imem_data_i  instruction memory address (= PC) and same-cycle data
//   pc_o, inst_o              IF/ID register: PC and instruction now in ID
//   branch_pred_o             IF/ID register: prediction made for inst_o
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] pc_jmp_i,
  input  logic        branch_i,
  input  logic [31:0] pc_branch_i,
  input  logic        branch_resolve_i,
  input  logic        branch_taken_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        branch_pred_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        redirect;

  assign redirect    = jmp_i | branch_i;
  assign imem_addr_o = pc_q;

`ifdef BRANCH_PRED_EN
  logic [BHT_IDX_W-1:0] bht_rd_idx;
  logic [BHT_IDX_W-1:0] bht_wr_idx;
  logic [1:0]           bht_rd_cnt;
  logic                 bht_we;
  logic                 pred_taken;
  logic                 id_pred_q;

  assign bht_rd_idx = pc_q[BHT_IDX_W+1:2];
  // The branch being resolved is the one sitting in IF/ID.
  assign bht_wr_idx = id_pc_q[BHT_IDX_W+1:2];
  // A stalled ID will present the same branch again, so only count it once.
  assign bht_we     = branch_resolve_i & ~stall_i;

  bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bht_rd_idx),
    .rd_cnt   (bht_rd_cnt),
    .wr_en    (bht_we),
    .wr_idx   (bht_wr_idx),
    .wr_taken (branch_taken_i)
  );

  assign pred_taken = (imem_data_i[6:0] == OPCODE_BRANCH) & bht_rd_cnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pred_q <= 1'b0;
    end else if (redirect) begin
      id_pred_q <= 1'b0;
    end else if (!stall_i) begin
      id_pred_q <= pred_taken;
    end
  end

  assign branch_pred_o = id_pred_q;
`else
  logic unused_pred_inputs;
  assign unused_pred_inputs = branch_resolve_i ^ branch_taken_i;
  assign branch_pred_o      = 1'b0;
`endif

  // Next-PC priority: jump, mispredict, stall, predicted-taken, sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (jmp_i) begin
      pc_d = pc_jmp_i;
    end else if (branch_i) begin
      pc_d = pc_branch_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
`ifdef BRANCH_PRED_EN
    else if (pred_taken) begin
      pc_d = pc_q + bimm(imem_data_i);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      id_pc_q   <= 32'h0;
      id_inst_q <= NOP_INST;
    end else begin
      pc_q <= pc_d;
      // A redirect kills the instruction fetched down the wrong path,
      // and must win over a stall so the bubble reaches ID.
      if (redirect) begin
        id_pc_q   <= 32'h0;
        id_inst_q <= NOP_INST;
      end else if (!stall_i) begin
        id_pc_q   <= pc_q;
        id_inst_q <= imem_data_i;
      end
    end
  end

  assign pc_o   = id_pc_q;
  assign inst_o = id_inst_q;

endmodule
